add_seq_ctrl: RTL and testbench

Sequencing controller for the 6-bit three-register add datapath. On a single `start` pulse it drives the datapath's register enables and operand-select lines through a fixed schedule:
- load X with a+b;
- load Y with X+3;
- accumulate X += Y a programmable number of times;
- present X+Y on the datapath result and pulse `done`.

It sits between the host/test FSM (start/iter/done/busy) and the datapath control inputs.

---
 rtl/add_seq_ctrl_if.sv | 28 ++
 rtl/add_seq_ctrl.sv | 102 ++++++++++
 tb/tb_add_seq_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/add_seq_ctrl_if.sv
// Control bundle between the host/test FSM, the add-sequence controller and
// the datapath select/enable inputs.
interface add_seq_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] iter;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cnt;
  logic             enx;
  logic             eny;
  logic             enz;
  logic             sa;
  logic             sb;
  logic             sy;
  logic             sc;

  modport master (
    output start, iter,
    input  busy, done, cnt, enx, eny, enz, sa, sb, sy, sc
  );

  modport slave (
    input  start, iter,
    output busy, done, cnt, enx, eny, enz, sa, sb, sy, sc
  );
endinterface

// File: rtl/add_seq_ctrl.sv
// Sequencer for the 6-bit three-register add datapath:
// X <= a+b, Y <= X+3, N times X <= X+Y, then present X+Y and pulse done.
module add_seq_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic          CLK,
  input  logic          RSTn,
  add_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDX  = 3'd1,
    S_LDY  = 3'd2,
    S_ACC  = 3'd3,
    S_OUT  = 3'd4
  } state_e;

  // Control word layout: {busy, done, enx, eny, enz, sa, sb, sy}
  function automatic logic [7:0] decode(input state_e s);
    logic [7:0] w;
    case (s)
      S_IDLE:  w = 8'b0000_0000;
      S_LDX:   w = 8'b1010_0110;
      S_LDY:   w = 8'b1001_0000;
      S_ACC:   w = 8'b1010_0001;
      S_OUT:   w = 8'b1100_1001;
      default: w = 8'b0000_0000;
    endcase
    return w;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       ctrl_q, ctrl_d;

  // Next state, step counter and the control word for the state being entered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LDX;
          cnt_d   = bus.iter;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LDX: state_d = S_LDY;
      S_LDY: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          state_d = S_ACC;
        end else begin
          state_d = S_OUT;
        end
      end
      S_ACC: begin
        // ACC is only entered with a non-zero count, the guard keeps it from wrapping
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_OUT;
        end else begin
          state_d = S_ACC;
        end
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Decoding the next state keeps outputs flopped yet aligned with state_q
    ctrl_d = decode(state_d);
  end

  // State, counter and control-word registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      ctrl_q  <= 8'b0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.busy = ctrl_q[7];
  assign bus.done = ctrl_q[6];
  assign bus.enx  = ctrl_q[5];
  assign bus.eny  = ctrl_q[4];
  assign bus.enz  = ctrl_q[3];
  assign bus.sa   = ctrl_q[2];
  assign bus.sb   = ctrl_q[1];
  assign bus.sy   = ctrl_q[0];
  assign bus.sc   = 1'b0;
  assign bus.cnt  = cnt_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl driving a behavioural 6-bit X/Y/Z datapath.
module tb_add_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  add_seq_ctrl_if #(.CNT_W(4)) bus ();

  add_seq_ctrl #(.CNT_W(4)) dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (bus)
  );

  // Behavioural datapath: operand muxes, adder and the three registers
  logic [5:0] a, b, x_q, y_q, z_q;
  logic [5:0] opa, opb, sum;
  assign opa = bus.sa ? a : x_q;
  assign opb = bus.sb ? b : (bus.sy ? y_q : 6'd3);
  assign sum = opa + opb;

  // Datapath register updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= 6'd0;
      y_q <= 6'd0;
      z_q <= 6'd0;
    end else begin
      if (bus.enx) x_q <= sum;
      if (bus.eny) y_q <= sum;
      if (bus.enz) z_q <= sum;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int onehot_err = 0;
  logic [5:0] xs [0:63];
  logic [5:0] ys [0:63];

  // One start pulse, then trace the sequence until it returns to idle
  task automatic run_seq(input logic [5:0] ia, input logic [5:0] ib, input logic [3:0] n,
                         output int done_off, output int busy_cnt, output int enx_cnt,
                         output int done_cnt, output logic [5:0] res);
    int en_sum;
    done_off = -1; busy_cnt = 0; enx_cnt = 0; done_cnt = 0; res = 6'd0;
    @(negedge clk);
    a = ia; b = ib; bus.iter = n; bus.start = 1'b1;
    for (int j = 1; j < 40; j++) begin
      @(negedge clk);
      if (j == 1) begin
        bus.start = 1'b0;
        bus.iter  = ~n;
      end
      xs[j] = x_q;
      ys[j] = y_q;
      en_sum = int'(bus.enx) + int'(bus.eny) + int'(bus.enz);
      if (en_sum != int'(bus.busy)) onehot_err++;
      if (bus.busy) busy_cnt++;
      if (bus.enx) enx_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_off = j - 1;
        res = sum;
      end
      if (j > 1 && !bus.busy) break;
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done, bus.enx, bus.eny, bus.enz, bus.sa, bus.sb, bus.sy, bus.sc} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected 000000000",
               {bus.busy, bus.done, bus.enx, bus.eny, bus.enz, bus.sa, bus.sb, bus.sy, bus.sc});
    end
    n_cmp++;
    if (bus.cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_cnt: got %0d expected 0", bus.cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int d_off, b_cnt, e_cnt, d_cnt;
    logic [5:0] r;
    run_seq(6'd5, 6'd7, 4'd2, d_off, b_cnt, e_cnt, d_cnt, r);
    n_cmp++; if (xs[2] !== 6'd12) begin n_bad++; $display("FAIL basic_x_ldx: got %0d expected 12", xs[2]); end
    n_cmp++; if (ys[3] !== 6'd15) begin n_bad++; $display("FAIL basic_y_ldy: got %0d expected 15", ys[3]); end
    n_cmp++; if (xs[4] !== 6'd27) begin n_bad++; $display("FAIL basic_x_acc1: got %0d expected 27", xs[4]); end
    n_cmp++; if (xs[5] !== 6'd42) begin n_bad++; $display("FAIL basic_x_acc2: got %0d expected 42", xs[5]); end
    n_cmp++; if (r !== 6'd57) begin n_bad++; $display("FAIL basic_result: got %0d expected 57", r); end
    n_cmp++; if (d_off != 4) begin n_bad++; $display("FAIL basic_done_latency: got %0d expected 4", d_off); end
    n_cmp++; if (b_cnt != 5) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d expected 5", b_cnt); end
    n_cmp++; if (d_cnt != 1) begin n_bad++; $display("FAIL basic_done_count: got %0d expected 1", d_cnt); end
    n_cmp++; if (z_q !== 6'd57) begin n_bad++; $display("FAIL basic_z: got %0d expected 57", z_q); end
  endtask

  task automatic test_zero_iter();
    int d_off, b_cnt, e_cnt, d_cnt;
    logic [5:0] r;
    run_seq(6'd5, 6'd7, 4'd0, d_off, b_cnt, e_cnt, d_cnt, r);
    n_cmp++; if (r !== 6'd27) begin n_bad++; $display("FAIL n0_result: got %0d expected 27", r); end
    n_cmp++; if (d_off != 2) begin n_bad++; $display("FAIL n0_done_latency: got %0d expected 2", d_off); end
    n_cmp++; if (e_cnt != 1) begin n_bad++; $display("FAIL n0_enx_cycles: got %0d expected 1", e_cnt); end
    n_cmp++; if (b_cnt != 3) begin n_bad++; $display("FAIL n0_busy_cycles: got %0d expected 3", b_cnt); end
  endtask

  task automatic test_wrap();
    int d_off, b_cnt, e_cnt, d_cnt;
    logic [5:0] r;
    run_seq(6'd63, 6'd63, 4'd1, d_off, b_cnt, e_cnt, d_cnt, r);
    n_cmp++; if (xs[2] !== 6'd62) begin n_bad++; $display("FAIL wrap_x_ldx: got %0d expected 62", xs[2]); end
    n_cmp++; if (ys[3] !== 6'd1) begin n_bad++; $display("FAIL wrap_y_ldy: got %0d expected 1", ys[3]); end
    n_cmp++; if (xs[4] !== 6'd63) begin n_bad++; $display("FAIL wrap_x_acc: got %0d expected 63", xs[4]); end
    n_cmp++; if (r !== 6'd0) begin n_bad++; $display("FAIL wrap_result: got %0d expected 0", r); end
    n_cmp++; if (d_off != 3) begin n_bad++; $display("FAIL wrap_done_latency: got %0d expected 3", d_off); end
  endtask

  task automatic test_back_to_back();
    int first = -1, last = -1, dones = 0, gap_err = 0;
    @(negedge clk);
    a = 6'd5; b = 6'd7; bus.iter = 4'd1; bus.start = 1'b1;
    for (int j = 1; j <= 25; j++) begin
      @(negedge clk);
      // Scramble iter while each run is in flight, restore it before the next accept
      if (j % 5 == 2) bus.iter = 4'd7;
      if (j % 5 == 4) bus.iter = 4'd1;
      if (bus.done) begin
        dones++;
        if (first < 0) first = j;
        if (last >= 0 && j - last != 5) gap_err++;
        last = j;
      end
    end
    bus.start = 1'b0;
    n_cmp++; if (first != 4) begin n_bad++; $display("FAIL b2b_first_done: got %0d expected 4", first); end
    n_cmp++; if (dones != 5) begin n_bad++; $display("FAIL b2b_done_count: got %0d expected 5", dones); end
    n_cmp++; if (gap_err != 0) begin n_bad++; $display("FAIL b2b_done_spacing: got %0d bad gaps expected 0", gap_err); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int found = 0, activity = 0;
    int d_off, b_cnt, e_cnt, d_cnt;
    logic [5:0] r;
    @(negedge clk);
    a = 6'd5; b = 6'd7; bus.iter = 4'd7; bus.start = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (j == 1) bus.start = 1'b0;
      if (bus.cnt === 4'd4) begin
        found = 1;
        break;
      end
    end
    n_cmp++; if (found != 1) begin n_bad++; $display("FAIL rstmid_reach_cnt4: got %0d expected 1", found); end
    n_cmp++; if (bus.enx !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_acc: got enx=%b expected 1", bus.enx); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.enx, bus.eny, bus.enz, bus.sa, bus.sb, bus.sy, bus.sc} !== 9'd0) begin
      n_bad++;
      $display("FAIL rstmid_ctrl: got %b expected 000000000",
               {bus.busy, bus.done, bus.enx, bus.eny, bus.enz, bus.sa, bus.sb, bus.sy, bus.sc});
    end
    n_cmp++; if (bus.cnt !== 4'd0) begin n_bad++; $display("FAIL rstmid_cnt: got %0d expected 0", bus.cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) activity++;
    end
    n_cmp++; if (activity != 0) begin n_bad++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", activity); end
    run_seq(6'd5, 6'd7, 4'd7, d_off, b_cnt, e_cnt, d_cnt, r);
    n_cmp++; if (d_off != 9) begin n_bad++; $display("FAIL rstmid_restart_latency: got %0d expected 9", d_off); end
    n_cmp++; if (b_cnt != 10) begin n_bad++; $display("FAIL rstmid_restart_busy: got %0d expected 10", b_cnt); end
  endtask

  task automatic test_random();
    int viol = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.sc !== 1'b0) viol++;
      if (int'(bus.enx) + int'(bus.eny) + int'(bus.enz) > 1) viol++;
      bus.start = 1'($urandom_range(0, 1));
      bus.iter  = 4'($urandom_range(0, 15));
      rst_n     = ($urandom_range(0, 49) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1; bus.start = 1'b0;
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL random_sc_onehot: got %0d violations expected 0", viol); end
    n_cmp++; if (onehot_err != 0) begin n_bad++; $display("FAIL seq_enable_per_state: got %0d errors expected 0", onehot_err); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.iter  = 4'd0;
    a = 6'd0;
    b = 6'd0;
    test_reset();
    test_basic();
    test_zero_iter();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
